// File: rtl/rcl_pkg.sv
// Shared definitions for the line/circle relation job scheduler.
// Contents: FSM state type, relation codes, default coefficient width.
package rcl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } rcl_state_e;

  localparam logic [1:0] REL_NONE    = 2'd0;
  localparam logic [1:0] REL_TANGENT = 2'd1;
  localparam logic [1:0] REL_SECANT  = 2'd2;

  localparam int unsigned RCL_COEF_W = 5;

endpackage

// File: rtl/rcl_rr_arbiter.sv
// Round-robin arbiter, purely combinational.
// Ports:
//   i_req   : request vector
//   i_ptr   : index of the last winner; search starts at i_ptr+1 (mod NUM_REQ)
//   o_grant : one-hot grant (all zero when no request)
//   o_idx   : index of the granted requester
//   o_any   : at least one request present
module rcl_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Offset NUM_REQ wraps back to i_ptr itself, so the last winner is checked last.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      w_cand = IDX_W'((32'(i_ptr) + off) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rcl_job_scheduler.sv
// Shares one line/circle relation engine among NUM_REQ requesters.
// A job {c,b,a} / {k,n,m} is accepted in one beat, streamed to the engine as three
// beats (a,m), (b,n), (c,k), and the engine result is returned tagged with the requester id.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester job handshake (req_ready is a one-hot pulse)
//   req_coef_L/Q        : per-requester packed {c,b,a} and {k,n,m}
//   eng_in_valid, eng_coef_L/Q : registered beat stream to the engine
//   eng_out_valid, eng_out     : engine result pulse and relation code
//   rsp_valid/rsp_ready, rsp_id, rsp_rel, rsp_timeout : response channel
module rcl_job_scheduler
  import rcl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned COEF_W  = RCL_COEF_W,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned ID_W = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*3*COEF_W-1:0] req_coef_L,
  input  logic [NUM_REQ*3*COEF_W-1:0] req_coef_Q,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        eng_in_valid,
  output logic [COEF_W-1:0]           eng_coef_L,
  output logic [COEF_W-1:0]           eng_coef_Q,
  input  logic                        eng_out_valid,
  input  logic [1:0]                  eng_out,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [1:0]                  rsp_rel,
  output logic                        rsp_timeout
);

  localparam int unsigned JOB_W = 3 * COEF_W;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  rcl_state_e        r_state, w_state_d;
  logic [ID_W-1:0]   r_ptr, w_ptr_d;
  logic [ID_W-1:0]   r_id, w_id_d;
  logic [1:0]        r_beat, w_beat_d;
  logic [CNT_W-1:0]  r_wait_cnt, w_wait_cnt_d;
  logic [JOB_W-1:0]  r_job_l, w_job_l_d;
  logic [JOB_W-1:0]  r_job_q, w_job_q_d;
  logic              r_eng_in_valid, w_eng_in_valid_d;
  logic [COEF_W-1:0] r_eng_coef_l, w_eng_coef_l_d;
  logic [COEF_W-1:0] r_eng_coef_q, w_eng_coef_q_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [1:0]        r_rsp_rel, w_rsp_rel_d;
  logic              r_rsp_timeout, w_rsp_timeout_d;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_any;

  rcl_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

  always_comb begin
    w_state_d        = r_state;
    w_ptr_d          = r_ptr;
    w_id_d           = r_id;
    w_beat_d         = r_beat;
    w_wait_cnt_d     = r_wait_cnt;
    w_job_l_d        = r_job_l;
    w_job_q_d        = r_job_q;
    w_eng_in_valid_d = 1'b0;
    w_eng_coef_l_d   = '0;
    w_eng_coef_q_d   = '0;
    w_rsp_valid_d    = r_rsp_valid;
    w_rsp_rel_d      = r_rsp_rel;
    w_rsp_timeout_d  = r_rsp_timeout;
    req_ready        = '0;

    unique case (r_state)
      IDLE: begin
        if (w_any) begin
          req_ready        = w_grant;
          w_job_l_d        = req_coef_L[w_gidx*JOB_W +: JOB_W];
          w_job_q_d        = req_coef_Q[w_gidx*JOB_W +: JOB_W];
          w_id_d           = w_gidx;
          w_ptr_d          = w_gidx;
          w_beat_d         = '0;
          // First beat is launched straight from the request bus so it lands one cycle after grant.
          w_eng_in_valid_d = 1'b1;
          w_eng_coef_l_d   = w_job_l_d[COEF_W-1:0];
          w_eng_coef_q_d   = w_job_q_d[COEF_W-1:0];
          w_state_d        = SEND;
        end
      end
      SEND: begin
        // r_beat is the beat currently on the engine bus; prepare the following one.
        if (r_beat == 2'd2) begin
          w_wait_cnt_d = '0;
          w_state_d    = WAIT;
        end else begin
          w_beat_d         = r_beat + 2'd1;
          w_eng_in_valid_d = 1'b1;
          w_eng_coef_l_d   = r_job_l[w_beat_d*COEF_W +: COEF_W];
          w_eng_coef_q_d   = r_job_q[w_beat_d*COEF_W +: COEF_W];
        end
      end
      WAIT: begin
        // A result on the last allowed cycle takes priority over the timeout.
        if (eng_out_valid) begin
          w_rsp_valid_d   = 1'b1;
          w_rsp_rel_d     = eng_out;
          w_rsp_timeout_d = 1'b0;
          w_state_d       = RESP;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_rsp_valid_d   = 1'b1;
          w_rsp_rel_d     = REL_NONE;
          w_rsp_timeout_d = 1'b1;
          w_state_d       = RESP;
        end else begin
          w_wait_cnt_d = r_wait_cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_d   = 1'b0;
          w_rsp_rel_d     = REL_NONE;
          w_rsp_timeout_d = 1'b0;
          w_state_d       = IDLE;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_ptr          <= ID_W'(NUM_REQ - 1);
      r_id           <= '0;
      r_beat         <= '0;
      r_wait_cnt     <= '0;
      r_job_l        <= '0;
      r_job_q        <= '0;
      r_eng_in_valid <= 1'b0;
      r_eng_coef_l   <= '0;
      r_eng_coef_q   <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_rel      <= '0;
      r_rsp_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_ptr          <= w_ptr_d;
      r_id           <= w_id_d;
      r_beat         <= w_beat_d;
      r_wait_cnt     <= w_wait_cnt_d;
      r_job_l        <= w_job_l_d;
      r_job_q        <= w_job_q_d;
      r_eng_in_valid <= w_eng_in_valid_d;
      r_eng_coef_l   <= w_eng_coef_l_d;
      r_eng_coef_q   <= w_eng_coef_q_d;
      r_rsp_valid    <= w_rsp_valid_d;
      r_rsp_rel      <= w_rsp_rel_d;
      r_rsp_timeout  <= w_rsp_timeout_d;
    end
  end

  assign eng_in_valid = r_eng_in_valid;
  assign eng_coef_L   = r_eng_coef_l;
  assign eng_coef_Q   = r_eng_coef_q;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_id       = r_id;
  assign rsp_rel      = r_rsp_rel;
  assign rsp_timeout  = r_rsp_timeout;

endmodule

// File: tb/tb_rcl_job_scheduler.sv
// Scoreboard bench for rcl_job_scheduler with a behavioural relation engine.
module tb_rcl_job_scheduler;

  localparam int NR = 4;
  localparam int W  = 5;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*3*W-1:0] req_coef_L;
  logic [NR*3*W-1:0] req_coef_Q;
  logic [NR-1:0]     req_ready;
  logic              eng_in_valid;
  logic [W-1:0]      eng_coef_L;
  logic [W-1:0]      eng_coef_Q;
  logic              eng_out_valid;
  logic [1:0]        eng_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [1:0]        rsp_rel;
  logic              rsp_timeout;

  always #5 clk = ~clk;

  rcl_job_scheduler #(
    .NUM_REQ(NR),
    .COEF_W (W),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_coef_L   (req_coef_L),
    .req_coef_Q   (req_coef_Q),
    .req_ready    (req_ready),
    .eng_in_valid (eng_in_valid),
    .eng_coef_L   (eng_coef_L),
    .eng_coef_Q   (eng_coef_Q),
    .eng_out_valid(eng_out_valid),
    .eng_out      (eng_out),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_rel      (rsp_rel),
    .rsp_timeout  (rsp_timeout)
  );

  typedef struct {
    int id;
    int rel;
    int to;
    int lat;  // cycles from the last engine beat to rsp_valid rising
  } rsp_t;

  rsp_t       exp_rsp_q[$];
  int         exp_grant_q[$];
  logic [9:0] exp_beat_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int eng_lat = 1;
  bit eng_mute = 1'b0;
  int last_beat_cyc = 0;
  int last_hs_cyc = -100;
  int last_grant_cyc = 0;
  bit in_flight = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [1:0] relation(input logic signed [W-1:0] a, b, c, m, n,
                                          input logic [W-1:0] k);
    int s, lhs, rhs;
    s   = int'(a) * int'(m) + int'(b) * int'(n) + int'(c);
    rhs = s * s;
    lhs = int'(k) * (int'(a) * int'(a) + int'(b) * int'(b));
    if (rhs < lhs) return 2'd2;
    if (rhs == lhs) return 2'd1;
    return 2'd0;
  endfunction

  // Behavioural engine: collects three beats, answers after eng_lat cycles.
  initial begin
    int cnt, cd;
    bit pend;
    logic signed [W-1:0] bl[3];
    logic signed [W-1:0] bq[3];
    logic [1:0] code;
    cnt = 0; cd = 0; pend = 1'b0; code = 2'd0;
    eng_out_valid = 1'b0;
    eng_out = 2'd0;
    forever begin
      @(negedge clk);
      eng_out_valid = 1'b0;
      if (!rst_n) begin
        cnt = 0;
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        cd--;
        if (cd == 0) begin
          eng_out_valid = 1'b1;
          eng_out = code;
          pend = 1'b0;
        end
      end
      if (eng_in_valid) begin
        if (exp_beat_q.size() == 0) fail_now("beat: unexpected engine beat");
        else check("beat {L,Q}", {eng_coef_L, eng_coef_Q}, exp_beat_q.pop_front());
        bl[cnt] = eng_coef_L;
        bq[cnt] = eng_coef_Q;
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          last_beat_cyc = cyc;
          code = relation(bl[0], bl[1], bl[2], bq[0], bq[1], bq[2]);
          pend = !eng_mute;
          cd = eng_lat;
        end
      end
    end
  end

  // Response monitor: stability while stalled, latency on rise, scoreboard pop on handshake.
  initial begin
    bit pv, pr, pto;
    logic [1:0] pid, prel;
    rsp_t e;
    pv = 1'b0; pr = 1'b0; pto = 1'b0; pid = '0; prel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (pv && !pr) begin
        check("rsp_valid held", rsp_valid, 1);
        check("rsp_id stable", rsp_id, pid);
        check("rsp_rel stable", rsp_rel, prel);
        check("rsp_timeout stable", rsp_timeout, pto);
      end
      if (rsp_valid && !pv && exp_rsp_q.size() != 0)
        check("rsp latency", cyc - last_beat_cyc, exp_rsp_q[0].lat);
      if (rsp_valid && rsp_ready) begin
        last_hs_cyc = cyc;
        in_flight = 1'b0;
        if (exp_rsp_q.size() == 0) begin
          fail_now("rsp: unexpected response");
        end else begin
          e = exp_rsp_q.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_rel", rsp_rel, e.rel);
          check("rsp_timeout", rsp_timeout, e.to);
        end
      end
      pv = rsp_valid; pr = rsp_ready; pid = rsp_id; prel = rsp_rel; pto = rsp_timeout;
    end
  end

  // Grant monitor: one-hot, single job in flight, round-robin order.
  initial begin
    int g;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_flight = 1'b0;
        continue;
      end
      if (req_ready != '0) begin
        check("req_ready onehot", $onehot(req_ready), 1);
        check("no job in flight at grant", in_flight, 0);
        g = -1;
        for (int i = 0; i < NR; i++) if (req_ready[i]) g = i;
        if (exp_grant_q.size() == 0) fail_now("grant: unexpected req_ready");
        else check("grant id", g, exp_grant_q.pop_front());
        in_flight = 1'b1;
        last_grant_cyc = cyc;
      end
    end
  end

  task automatic load(input int i, input int a, b, c, m, n, k);
    req_coef_L[i*3*W +: 3*W] = {c[W-1:0], b[W-1:0], a[W-1:0]};
    req_coef_Q[i*3*W +: 3*W] = {k[W-1:0], n[W-1:0], m[W-1:0]};
  endtask

  task automatic expect_job(input int id, input int a, b, c, m, n, k,
                            input int rel, to, lat, input bit with_rsp);
    rsp_t e;
    exp_grant_q.push_back(id);
    exp_beat_q.push_back({a[W-1:0], m[W-1:0]});
    exp_beat_q.push_back({b[W-1:0], n[W-1:0]});
    exp_beat_q.push_back({c[W-1:0], k[W-1:0]});
    if (with_rsp) begin
      e.id = id; e.rel = rel; e.to = to; e.lat = lat;
      exp_rsp_q.push_back(e);
    end
  endtask

  // Returns at posedge+1 of the cycle after the grant, with the request withdrawn.
  task automatic wait_grant(input int i);
    int t;
    for (t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    if (t == 300) fail_now($sformatf("grant wait expired for req%0d", i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 400; t++) begin
      @(negedge clk);
      if (exp_rsp_q.size() == 0 && !in_flight) break;
    end
    if (t == 400) fail_now("drain wait expired");
    @(posedge clk); #1;
  endtask

  initial begin
    int t, seen;
    rst_n = 1'b0;
    req_valid = '0;
    req_coef_L = '0;
    req_coef_Q = '0;
    rsp_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset eng_in_valid", eng_in_valid, 0);
    check("reset eng_coef_L", eng_coef_L, 0);
    check("reset eng_coef_Q", eng_coef_Q, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset rsp_rel", rsp_rel, 0);
    check("reset rsp_timeout", rsp_timeout, 0);
    check("reset req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All four requesters held: order 0,1,2,3,0
    eng_lat = 2;
    load(0, 1, 0, 0, 0, 0, 4);
    load(1, 0, 1, -1, 0, 0, 1);
    load(2, 1, 1, 0, 3, 3, 2);
    load(3, -1, 2, 3, 1, -1, 9);
    expect_job(0, 1, 0, 0, 0, 0, 4, 2, 0, 3, 1);
    expect_job(1, 0, 1, -1, 0, 0, 1, 1, 0, 3, 1);
    expect_job(2, 1, 1, 0, 3, 3, 2, 0, 0, 3, 1);
    expect_job(3, -1, 2, 3, 1, -1, 9, 2, 0, 3, 1);
    expect_job(0, 1, 0, 0, 0, 0, 4, 2, 0, 3, 1);
    req_valid = 4'hF;
    seen = 0;
    for (t = 0; t < 300 && seen < 5; t++) begin
      @(negedge clk);
      if (req_ready != '0) seen++;
    end
    if (seen < 5) fail_now("held requests: fewer than 5 grants");
    @(posedge clk); #1;
    req_valid = '0;
    drain();

    // Single job from req0, secant, engine latency 1
    eng_lat = 1;
    load(0, 1, 0, 0, 0, 0, 4);
    expect_job(0, 1, 0, 0, 0, 0, 4, 2, 0, 2, 1);
    req_valid[0] = 1'b1;
    wait_grant(0);
    drain();

    // Req1 tangent then no contact, engine latency 3
    eng_lat = 3;
    load(1, 1, 0, -2, 0, 0, 4);
    expect_job(1, 1, 0, -2, 0, 0, 4, 1, 0, 4, 1);
    req_valid[1] = 1'b1;
    wait_grant(1);
    drain();
    load(1, 1, 0, -3, 0, 0, 4);
    expect_job(1, 1, 0, -3, 0, 0, 4, 0, 0, 4, 1);
    req_valid[1] = 1'b1;
    wait_grant(1);
    drain();

    // Timeout: silent engine, pulse on final WAIT cycle, pulse one cycle too late
    load(2, 1, 0, 0, 0, 0, 4);
    eng_mute = 1'b1;
    expect_job(2, 1, 0, 0, 0, 0, 4, 0, 1, TO + 1, 1);
    req_valid[2] = 1'b1;
    wait_grant(2);
    drain();
    eng_mute = 1'b0;
    eng_lat = TO;
    expect_job(2, 1, 0, 0, 0, 0, 4, 2, 0, TO + 1, 1);
    req_valid[2] = 1'b1;
    wait_grant(2);
    drain();
    eng_lat = TO + 1;
    expect_job(2, 1, 0, 0, 0, 0, 4, 0, 1, TO + 1, 1);
    req_valid[2] = 1'b1;
    wait_grant(2);
    drain();

    // Back-pressure: rsp_ready low for 5 cycles while req1 waits
    eng_lat = 1;
    rsp_ready = 1'b0;
    load(3, -1, 2, 3, 1, -1, 9);
    expect_job(3, -1, 2, 3, 1, -1, 9, 2, 0, 2, 1);
    req_valid[3] = 1'b1;
    wait_grant(3);
    load(1, 1, 0, -3, 0, 0, 4);
    expect_job(1, 1, 0, -3, 0, 0, 4, 0, 0, 2, 1);
    req_valid[1] = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    if (t == 100) fail_now("rsp_valid wait expired");
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_grant(1);
    check("grant one cycle after handshake", last_grant_cyc - last_hs_cyc, 1);
    drain();

    // Reset during SEND beat 1, then pointer restart favours req0
    load(0, 1, 0, 0, 0, 0, 4);
    expect_job(0, 1, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    req_valid[0] = 1'b1;
    wait_grant(0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_beat_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid-job reset eng_in_valid", eng_in_valid, 0);
    check("mid-job reset eng_coef_L", eng_coef_L, 0);
    check("mid-job reset eng_coef_Q", eng_coef_Q, 0);
    check("mid-job reset rsp_valid", rsp_valid, 0);
    check("mid-job reset rsp_id", rsp_id, 0);
    check("mid-job reset rsp_rel", rsp_rel, 0);
    check("mid-job reset rsp_timeout", rsp_timeout, 0);
    check("mid-job reset req_ready", req_ready, 0);
    @(posedge clk); #1;
    load(1, 1, 0, -2, 0, 0, 4);
    expect_job(0, 1, 0, 0, 0, 0, 4, 2, 0, 2, 1);
    expect_job(1, 1, 0, -2, 0, 0, 4, 1, 0, 2, 1);
    req_valid = 4'b0011;
    wait_grant(0);
    wait_grant(1);
    drain();

    repeat (3) @(posedge clk);
    check("rsp scoreboard empty", exp_rsp_q.size(), 0);
    check("grant scoreboard empty", exp_grant_q.size(), 0);
    check("beat scoreboard empty", exp_beat_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (%0d checks, %0d errors)",
             n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
